// File: rtl/detector_xcheck_pkg.sv
// detector_xcheck_pkg
// Shared types and helpers for the Mealy/Moore detector cross-checker.
//   state_t   : checker FSM state (WARMUP, COMPARE, FAULT), 2-bit encoding
//   DEF_*     : default parameter values used by detector_xcheck
//   sat_inc   : saturating increment for counters up to 32 bits wide
package detector_xcheck_pkg;

   typedef enum logic [1:0] {
      WARMUP  = 2'd0,
      COMPARE = 2'd1,
      FAULT   = 2'd2
   } state_t;

   localparam int DEF_CNT_W      = 8;
   localparam int DEF_CYC_W      = 16;
   localparam int DEF_LAT        = 1;
   localparam int DEF_WARMUP_CYC = 2;

   // Increment value unless it already sits at the all-ones value of a
   // counter that is 'width' bits wide. Callers zero-extend into and
   // truncate out of the 32-bit working width.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input int unsigned width);
      logic [31:0] max_val;
      if (width >= 32)
         max_val = '1;
      else
         max_val = (32'd1 << width) - 32'd1;
      if (value == max_val)
         return value;
      else
         return value + 32'd1;
   endfunction

endpackage

// File: rtl/bit_delay_line.sv
// bit_delay_line
// Delays a single-bit stream by LAT clock cycles so that one detector's
// output can be lined up against another detector that answers later.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears the line
//   clr  : synchronous clear, clears the line (sample on that edge dropped)
//   din  : bit entering the line
//   dout : din delayed by LAT cycles (combinational pass-through when LAT=0)
module bit_delay_line #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic din,
   output logic dout
);

   generate
      if (LAT == 0) begin : g_passthru
         assign dout = din;
      end else begin : g_shift
         logic [LAT-1:0] sr;

         // Shift toward the MSB; the oldest sample leaves from the top bit.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               sr <= '0;
            else if (clr)
               sr <= '0;
            else
               sr <= (sr << 1) | LAT'(din);
         end

         assign dout = sr[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/detector_xcheck.sv
// detector_xcheck
// Synthesizable self-check placed after a Mealy/Moore sequence-detector
// pair. The Mealy output is delayed to line up with the Moore output, then
// the two are compared once a short warm-up has elapsed. Detections and
// mismatches are counted, and the first disagreement latches a sticky fault
// together with the cycle stamp at which it happened.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : synchronous clear of all state, wins over everything
//   mealy_in        : Mealy detector output
//   moore_in        : Moore detector output
//   det_count       : cycles with moore_in=1 (saturating)
//   mism_count      : compared cycles with a mismatch (saturating)
//   err             : sticky fault flag
//   first_mism_cyc  : cycle stamp of the first mismatch
//   cmp_valid       : comparison active (COMPARE or FAULT)
module detector_xcheck
   import detector_xcheck_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int CYC_W      = DEF_CYC_W,
   parameter int LAT        = DEF_LAT,
   parameter int WARMUP_CYC = DEF_WARMUP_CYC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             mealy_in,
   input  logic             moore_in,
   output logic [CNT_W-1:0] det_count,
   output logic [CNT_W-1:0] mism_count,
   output logic             err,
   output logic [CYC_W-1:0] first_mism_cyc,
   output logic             cmp_valid
);

   state_t           state;
   state_t           state_next;
   logic [3:0]       wcnt;
   logic [3:0]       wcnt_next;
   logic [CYC_W-1:0] cyc;
   logic             mealy_al;
   logic             mism;
   logic             capture;
   logic             cmp_active;

   bit_delay_line #(
      .LAT (LAT)
   ) u_align (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .din  (mealy_in),
      .dout (mealy_al)
   );

   assign mism       = mealy_al ^ moore_in;
   assign cmp_active = (state == COMPARE) || (state == FAULT);

   // Next-state logic. The cycle on which WARMUP hands over to COMPARE is
   // still a warm-up cycle, so a mismatch there is ignored. FAULT only
   // leaves through rst or clr, handled in the register block.
   always_comb begin
      state_next = state;
      wcnt_next  = wcnt;
      capture    = 1'b0;
      case (state)
         WARMUP: begin
            if (wcnt == 4'(WARMUP_CYC - 1)) begin
               state_next = COMPARE;
               wcnt_next  = '0;
            end else begin
               wcnt_next = wcnt + 4'd1;
            end
         end
         COMPARE: begin
            if (mism) begin
               state_next = FAULT;
               capture    = 1'b1;
            end
         end
         FAULT: begin
            state_next = FAULT;
         end
         default: begin
            state_next = WARMUP;
            wcnt_next  = '0;
         end
      endcase
   end

   // State, stamp and counters. clr behaves like a synchronous reset and
   // discards whatever the inputs carry on that edge. err and cmp_valid are
   // registered from the next state so they track the FSM without a
   // decode path on the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= WARMUP;
         wcnt           <= '0;
         cyc            <= '0;
         det_count      <= '0;
         mism_count     <= '0;
         first_mism_cyc <= '0;
         err            <= 1'b0;
         cmp_valid      <= 1'b0;
      end else if (clr) begin
         state          <= WARMUP;
         wcnt           <= '0;
         cyc            <= '0;
         det_count      <= '0;
         mism_count     <= '0;
         first_mism_cyc <= '0;
         err            <= 1'b0;
         cmp_valid      <= 1'b0;
      end else begin
         state     <= state_next;
         wcnt      <= wcnt_next;
         cyc       <= CYC_W'(sat_inc(32'(cyc), CYC_W));
         err       <= (state_next == FAULT);
         cmp_valid <= (state_next != WARMUP);
         if (moore_in)
            det_count <= CNT_W'(sat_inc(32'(det_count), CNT_W));
         if (cmp_active && mism)
            mism_count <= CNT_W'(sat_inc(32'(mism_count), CNT_W));
         if (capture)
            first_mism_cyc <= cyc;
      end
   end

endmodule

// File: tb/tb_detector_xcheck.sv
// tb_detector_xcheck
// Directed bench for detector_xcheck with default parameters
// (CNT_W=8, CYC_W=16, LAT=1, WARMUP_CYC=2). Inputs change 1ns after a
// rising edge and outputs are checked at that same point, so each
// applyStimulus call is one cycle whose inputs are sampled on the next edge.
// Cycle n after a clr is the cycle in which the internal stamp reads n.
module tb_detector_xcheck;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       mealy_in;
   logic       moore_in;
   logic [7:0] det_count;
   logic [7:0] mism_count;
   logic       err;
   logic [15:0] first_mism_cyc;
   logic       cmp_valid;

   int vec_count;
   int miscompare_count;

   detector_xcheck dut (
      .clk            (clk),
      .rst            (rst),
      .clr            (clr),
      .mealy_in       (mealy_in),
      .moore_in       (moore_in),
      .det_count      (det_count),
      .mism_count     (mism_count),
      .err            (err),
      .first_mism_cyc (first_mism_cyc),
      .cmp_valid      (cmp_valid)
   );

   // 10ns clock, first rising edge at 5ns.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, then land 1ns after the edge that samples them.
   task automatic applyStimulus(input logic m, input logic o, input logic c);
      mealy_in = m;
      moore_in = o;
      clr      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vec_count++;
      assert (observed === expected)
      else begin
         miscompare_count++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      vec_count        = 0;
      miscompare_count = 0;
      rst      = 1'b1;
      clr      = 1'b0;
      mealy_in = 1'b0;
      moore_in = 1'b0;

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_det", 32'(det_count), 0);
      checkOutput("rst_mism", 32'(mism_count), 0);
      checkOutput("rst_err", 32'(err), 0);
      checkOutput("rst_first", 32'(first_mism_cyc), 0);
      checkOutput("rst_valid", 32'(cmp_valid), 0);
      rst = 1'b0;

      // Quiet inputs: only cmp_valid moves, rising after the second edge.
      for (int n = 0; n < 10; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("quiet_valid", 32'(cmp_valid), (n >= 1) ? 1 : 0);
         checkOutput("quiet_det", 32'(det_count), 0);
         checkOutput("quiet_mism", 32'(mism_count), 0);
         checkOutput("quiet_err", 32'(err), 0);
      end

      // Consistent pair: Moore echoes Mealy one cycle later.
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 16; n++)
         applyStimulus(n == 4 || n == 9 || n == 13, n == 5 || n == 10 || n == 14, 1'b0);
      checkOutput("cons_det", 32'(det_count), 3);
      checkOutput("cons_mism", 32'(mism_count), 0);
      checkOutput("cons_err", 32'(err), 0);
      checkOutput("cons_first", 32'(first_mism_cyc), 0);
      checkOutput("cons_valid", 32'(cmp_valid), 1);

      // Missing Moore pulse at 10, extra Moore pulse at 20.
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 22; n++) begin
         applyStimulus(n == 4 || n == 9 || n == 13, n == 5 || n == 14 || n == 20, 1'b0);
         if (n == 9)
            checkOutput("miss_err_before", 32'(err), 0);
         if (n == 10) begin
            checkOutput("miss_err", 32'(err), 1);
            checkOutput("miss_first", 32'(first_mism_cyc), 10);
            checkOutput("miss_mism", 32'(mism_count), 1);
         end
         if (n == 19)
            checkOutput("miss_mism_hold", 32'(mism_count), 1);
      end
      checkOutput("extra_mism", 32'(mism_count), 2);
      checkOutput("extra_first", 32'(first_mism_cyc), 10);
      checkOutput("extra_det", 32'(det_count), 3);
      checkOutput("extra_err", 32'(err), 1);

      // clr while in FAULT with a mismatch on the same edge: clr wins.
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("clr_err", 32'(err), 0);
      checkOutput("clr_det", 32'(det_count), 0);
      checkOutput("clr_mism", 32'(mism_count), 0);
      checkOutput("clr_first", 32'(first_mism_cyc), 0);
      checkOutput("clr_valid", 32'(cmp_valid), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("clr_valid_c0", 32'(cmp_valid), 0);
      // Mismatch on the WARMUP->COMPARE cycle is not compared.
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("clr_valid_c1", 32'(cmp_valid), 1);
      checkOutput("handover_err", 32'(err), 0);
      checkOutput("handover_mism", 32'(mism_count), 0);
      checkOutput("handover_det", 32'(det_count), 1);

      // Saturation: Moore stuck high for 300 cycles.
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 300; n++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         if (n == 99) begin
            checkOutput("sat_det_mid", 32'(det_count), 100);
            checkOutput("sat_mism_mid", 32'(mism_count), 98);
         end
      end
      checkOutput("sat_det", 32'(det_count), 255);
      checkOutput("sat_mism", 32'(mism_count), 255);
      checkOutput("sat_err", 32'(err), 1);
      checkOutput("sat_first", 32'(first_mism_cyc), 2);

      // Asynchronous reset in the middle of a clock period during COMPARE.
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 8; n++)
         applyStimulus(n == 4, n == 5, 1'b0);
      checkOutput("pre_arst_det", 32'(det_count), 1);
      checkOutput("pre_arst_valid", 32'(cmp_valid), 1);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("arst_det", 32'(det_count), 0);
      checkOutput("arst_valid", 32'(cmp_valid), 0);
      checkOutput("arst_err", 32'(err), 0);
      checkOutput("arst_mism", 32'(mism_count), 0);
      checkOutput("arst_first", 32'(first_mism_cyc), 0);
      #2;
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
      $finish;
   end

endmodule

// File: doc/detector_xcheck.md
# detector_xcheck

Downstream checker for the sequence-detector pair: consumes the Mealy and Moore detector outputs cycle by cycle and aligns the Mealy output to the Moore output's one-clock lag. It then counts detections and mismatches, and latches a sticky fault with the cycle stamp of the first disagreement. It replaces the bench-level XOR comparison with a synthesizable self-check that sits directly after the two detector instances.

## Interface
- CNT_W, 8: width of detection and mismatch counters (saturating)
- CYC_W, 16: width of free-running cycle stamp (saturating)
- LAT, 1: clock cycles the Moore output lags the Mealy output; legal 0..4
- WARMUP_CYC, 2: cycles after reset/clear during which comparison is suppressed; legal 1..15

Ports:
- clk  in  1  rising-edge clock shared with both detectors
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of counters, stamp, delay line and FSM; priority over all other updates
- mealy_in  in  1  Mealy detector output
- moore_in  in  1  Moore detector output
- det_count  out  CNT_W  number of cycles with moore_in=1 since reset/clear
- mism_count  out  CNT_W  number of compared cycles with aligned mealy != moore_in
- err  out  1  sticky fault flag, high while FSM is in FAULT
- first_mism_cyc  out  CYC_W  cycle stamp captured at the first mismatch
- cmp_valid  out  1  high while comparison is active (COMPARE or FAULT)

## Operation
- Alignment: mealy_in passes through a LAT-stage shift register. mealy_al is the delayed value; for LAT=0, mealy_al = mealy_in.
- Cycle stamp: cyc increments every clock from 0 after reset/clear and saturates at all-ones.
- FSM states:
  - WARMUP: wcnt counts 0..WARMUP_CYC-1, then goes to COMPARE.
  - COMPARE: on mismatch (mealy_al != moore_in), goes to FAULT and captures cyc into first_mism_cyc in the same edge.
  - FAULT: absorbing; only rst or clr leave it, both to WARMUP.
- Counting:
  - det_count increments on every cycle with moore_in=1, in every state including WARMUP.
  - mism_count increments on every mismatching cycle while in COMPARE or FAULT.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Capture: first_mism_cyc is written only on the COMPARE->FAULT transition. Later mismatches do not overwrite it.
- clr asserted: on the next edge, all counters, cyc, wcnt, the delay line and first_mism_cyc are 0, and the FSM is in WARMUP. Inputs sampled on that edge are discarded.
- Reset mid-operation: everything returns to its reset value immediately. There is no partial state retention.

## Timing
- Reset values: det_count=0, mism_count=0, err=0, first_mism_cyc=0, cmp_valid=0, FSM=WARMUP, delay line all 0, cyc=0.
- All outputs are registered. A mismatch sampled at edge N is visible on mism_count and err after edge N.
- cmp_valid rises after edge WARMUP_CYC following reset release or clr.
- A mismatch on the same cycle as the WARMUP->COMPARE transition is not compared.
- Simultaneous clr and mismatch: clr wins, and the counters read 0.
- Saturated counter plus a new event: the value holds, with no flag and no wrap.

## Structure
- Package detector_xcheck_pkg:
  - FSM state typedef {WARMUP, COMPARE, FAULT}, 2-bit encoding
  - default-width localparams
  - saturating-increment function
- One sub-module: bit_delay_line, parameterised by LAT, with clk/rst/clr. It implements the alignment register and is reusable for other detector pairs.
- Top level holds the FSM, warm-up counter, cycle stamp and the two counters.

## Test plan
- Reset release, both inputs 0 for 10 cycles -> all outputs 0 except cmp_valid, which rises after cycle 2.
- Consistent pair: mealy_in pulses at cycles 4, 9, 13 and moore_in pulses at 5, 10, 14 (LAT=1) -> det_count=3, mism_count=0, err=0.
- Moore pulse missing at cycle 10 while Mealy fired at 9 -> err=1 after edge 10, first_mism_cyc=10, mism_count=1. A later extra mismatch at 20 gives mism_count=2 with first_mism_cyc still 10.
- Assert clr for one cycle while in FAULT -> next edge: err=0, counters 0, cmp_valid=0, then cmp_valid=1 two cycles later.
- Hold moore_in=1 with mealy_in=0 for 300 cycles (CNT_W=8) -> det_count and mism_count both saturate at 255.
- Assert rst asynchronously mid-clock during COMPARE with nonzero counts -> outputs go to 0 before the next clk edge.
